// File: rtl/jtframe_cen_pkg.sv
// Shared types and defaults for the fractional clock-enable scheduler.
package jtframe_cen_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSED = 2'd1,
    STEP   = 2'd2
  } state_t;

  localparam int DEF_NUM = 1;
  localparam int DEF_DEN = 2;
  localparam int CEN_W   = 10;

  // Channel-select width; a single channel still needs one select bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jtframe_cen_ctrl_if.sv
// Configuration write handshake between software/OSD and the cen scheduler.
interface jtframe_cen_ctrl_if
  import jtframe_cen_pkg::*;
#(
  parameter int NCH = 3,
  parameter int W   = CEN_W
);

  localparam int CH_W = ch_width(NCH);

  logic            cfg_we;
  logic [CH_W-1:0] cfg_ch;
  logic [W-1:0]    cfg_num;
  logic [W-1:0]    cfg_den;
  logic            cfg_busy;
  logic            cfg_err;

  modport master (output cfg_we, cfg_ch, cfg_num, cfg_den, input  cfg_busy, cfg_err);
  modport slave  (input  cfg_we, cfg_ch, cfg_num, cfg_den, output cfg_busy, cfg_err);

endinterface

// File: rtl/jtframe_cen_frac.sv
// Single-channel fractional accumulator: cen averages num/den of the clock.
module jtframe_cen_frac
  import jtframe_cen_pkg::*;
#(
  parameter int W       = CEN_W,
  parameter int DEF_NUM = jtframe_cen_pkg::DEF_NUM,
  parameter int DEF_DEN = jtframe_cen_pkg::DEF_DEN
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         advance,
  input  logic         load,
  input  logic [W-1:0] load_num,
  input  logic [W-1:0] load_den,
  output logic         cen,
  output logic         pulse_next,
  output logic         stopped
);

  logic [W-1:0] num;
  logic [W-1:0] den;
  logic [W-1:0] acc;
  logic [W:0]   sum;
  logic [W:0]   diff;

  assign sum        = {1'b0, acc} + {1'b0, num};
  assign diff       = sum - {1'b0, den};
  assign stopped    = (num == '0);
  // High when this edge will register a cen pulse; a load on the same
  // edge still lets the pulse through so the old period ends intact.
  assign pulse_next = advance && !stopped && (sum >= {1'b0, den});

  // Accumulator update, rate reload and registered cen output.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      num <= DEF_NUM[W-1:0];
      den <= DEF_DEN[W-1:0];
      cen <= 1'b0;
    end else begin
      cen <= pulse_next;
      if (load) begin
        num <= load_num;
        den <= load_den;
        acc <= '0;
      end else if (pulse_next) begin
        acc <= diff[W-1:0];
      end else if (advance && !stopped) begin
        acc <= sum[W-1:0];
      end
    end
  end

endmodule

// File: rtl/jtframe_cen_ctrl.sv
// Multi-channel fractional cen scheduler with one-deep rate reprogramming
// and a global pause/single-step controller.
module jtframe_cen_ctrl
  import jtframe_cen_pkg::*;
#(
  parameter int NCH     = 3,
  parameter int W       = CEN_W,
  parameter int DEF_NUM = jtframe_cen_pkg::DEF_NUM,
  parameter int DEF_DEN = jtframe_cen_pkg::DEF_DEN
) (
  input  logic                     clk,
  input  logic                     rst,
  jtframe_cen_ctrl_if.slave        cfg,
  input  logic                     pause,
  input  logic                     step,
  output logic                     paused,
  output logic [NCH-1:0]           cen
);

  localparam int CH_W = ch_width(NCH);
  localparam logic [CH_W:0] NCH_C = NCH[CH_W:0];

  state_t          state;
  state_t          state_nx;

  logic            pend_vld;
  logic [CH_W-1:0] pend_ch;
  logic [W-1:0]    pend_num;
  logic [W-1:0]    pend_den;
  logic            err_q;

  logic            cfg_ok;
  logic            accept;
  logic            apply;

  logic [NCH-1:0]  advance;
  logic [NCH-1:0]  load;
  logic [NCH-1:0]  pulse_next;
  logic [NCH-1:0]  stopped;
  logic [NCH-1:0]  done;
  logic [NCH-1:0]  done_nx;

  assign cfg_ok = (cfg.cfg_den != '0) &&
                  (cfg.cfg_num <= cfg.cfg_den) &&
                  ({1'b0, cfg.cfg_ch} < NCH_C);
  assign accept = cfg.cfg_we && !pend_vld;

  // A pending write lands when the target is at a period boundary, is
  // stopped, or everything is frozen, so no pulse is ever cut short.
  assign apply  = pend_vld &&
                  (pulse_next[pend_ch] || stopped[pend_ch] || state == PAUSED);

  assign cfg.cfg_busy = pend_vld;
  assign cfg.cfg_err  = err_q;
  assign paused       = (state == PAUSED);

  // Stopped channels have nothing to emit and count as stepped at once.
  assign done_nx = done | pulse_next | stopped;

  // Pending-slot control and the one-cycle reject pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (accept) begin
        if (cfg_ok) pend_vld <= 1'b1;
        else        err_q    <= 1'b1;
      end else if (apply) begin
        pend_vld <= 1'b0;
      end
    end
  end

  // Pending write payload, captured only when a valid write is accepted.
  always_ff @(posedge clk) begin
    if (accept && cfg_ok) begin
      pend_ch  <= cfg.cfg_ch;
      pend_num <= cfg.cfg_num;
      pend_den <= cfg.cfg_den;
    end
  end

  // Pause/step state register.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nx;
  end

  // Next-state selection and per-channel advance gating.
  always_comb begin
    state_nx = state;
    advance  = '0;
    unique case (state)
      RUN: begin
        advance = '1;
        if (pause) state_nx = PAUSED;
      end
      PAUSED: begin
        if (!pause)    state_nx = RUN;
        else if (step) state_nx = STEP;
      end
      STEP: begin
        advance = ~done;
        if (!pause)         state_nx = RUN;
        else if (&done_nx)  state_nx = PAUSED;
      end
      default: state_nx = RUN;
    endcase
  end

  // Step-done flags live only while stepping; any exit clears them.
  always_ff @(posedge clk) begin
    if (rst)                                    done <= '0;
    else if (state == STEP && state_nx == STEP) done <= done_nx;
    else                                        done <= '0;
  end

  // Reload strobe for the targeted channel.
  always_comb begin
    load = '0;
    if (apply) load[pend_ch] = 1'b1;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    jtframe_cen_frac #(
      .W       (W),
      .DEF_NUM (DEF_NUM),
      .DEF_DEN (DEF_DEN)
    ) u_frac (
      .clk        (clk),
      .rst        (rst),
      .advance    (advance[i]),
      .load       (load[i]),
      .load_num   (pend_num),
      .load_den   (pend_den),
      .cen        (cen[i]),
      .pulse_next (pulse_next[i]),
      .stopped    (stopped[i])
    );
  end

endmodule

// File: doc/jtframe_cen_ctrl.md
Name: jtframe_cen_ctrl

Overview:
- Runtime-configurable, multi-channel fractional clock-enable scheduler for the 24 MHz system clock.
- Each channel produces cen pulses at an average rate of clk × num/den. Software and the OSD reprogram the rates through a one-deep write handshake.
- A global pause/single-step controller gates all channels together, for debug freeze and frame stepping.
- It replaces fixed-ratio enable dividers where the core needs selectable CPU/sound speeds.

Parameters:
- NCH, 3, number of cen channels.
- W, 10, width of num/den fields.
- DEF_NUM, 1, num loaded into every channel at reset.
- DEF_DEN, 2, den loaded into every channel at reset (gives 12 MHz from 24 MHz).

Ports:
- clk  in  1  system clock, 24 MHz
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  config write strobe
- cfg_ch  in  clog2(NCH)  target channel
- cfg_num  in  W  new numerator
- cfg_den  in  W  new denominator
- cfg_busy  out  1  a write is pending and not yet applied
- cfg_err  out  1  one-cycle pulse when a write is rejected
- pause  in  1  level; freeze request
- step  in  1  one-cycle pulse; single-step request while paused
- paused  out  1  high in PAUSED state
- cen  out  NCH  registered clock-enable pulses, one per channel

Behaviour:
- Reset (synchronous, rst=1):
  - Every channel: acc=0, num=DEF_NUM, den=DEF_DEN.
  - cen=0, cfg_busy=0, cfg_err=0, paused=0, state=RUN, step-done flags cleared, pending write discarded.
  - Reset asserted mid-step or mid-pending-write aborts that operation.
- Accumulator, per channel, on each cycle the channel is advancing:
  - Compute sum = acc + num, W+1 bits.
  - If sum >= den: acc <= sum - den and cen[i] <= 1. Otherwise acc <= sum and cen[i] <= 0.
  - A non-advancing channel holds acc and drives cen[i] = 0.
  - num=0 means the channel is stopped: cen stays 0 and acc holds.
- Timing: cen is registered.
  - Defaults 1/2: first pulse on the 2nd clk after rst falls, then every 2 clk.
  - 1/12 gives a 2 MHz pulse every 12 clk.
  - num=den gives cen high every cycle.
- Config handshake:
  - Accept: cfg_we=1 while cfg_busy=0. Values are latched into a single pending slot and cfg_busy=1 from the next cycle.
  - Ignore: cfg_we while cfg_busy=1; no error is raised.
  - Reject: den=0, num>den, or cfg_ch>=NCH. cfg_err pulses one cycle later, nothing is latched, cfg_busy stays 0.
  - Apply point, first of:
    - (a) the edge on which the target channel registers a cen pulse;
    - (b) any cycle in which the target has num=0;
    - (c) any cycle in state PAUSED.
  - On apply: num/den are loaded, acc is reset to 0, and cfg_busy falls the next cycle.
  - In case (a) the pulse itself still occurs, so the old period completes intact and no pulse is glitched or dropped.
- State machine:
  - RUN: all channels advance. pause=1 → PAUSED next cycle.
  - PAUSED: no channel advances, paused=1.
    - pause=0 → RUN.
    - step=1 (with pause=1) → STEP, done flags cleared.
    - If pause falls and step rises in the same cycle, pause=0 wins (RUN).
  - STEP: channels advance until each has emitted exactly one cen pulse.
    - After its pulse, a channel sets its done flag and holds.
    - A channel with num=0 counts as done immediately.
    - When all flags are set → PAUSED.
    - pause=0 during STEP → RUN; flags cleared.
    - step is ignored in RUN and STEP.
- Hold semantics: a paused channel holds acc exactly, so the phase is preserved across pause/resume.

Decomposition:
- Shared package jtframe_cen_pkg:
  - state enum {RUN, PAUSED, STEP};
  - constants DEF_NUM, DEF_DEN, CEN_W.
- One sub-module, jtframe_cen_frac: a single-channel accumulator.
  - Inputs: advance, num, den, load, load_num, load_den.
  - Outputs: cen, pulse_next.
  - Instantiated NCH times.
- Top level: handshake logic, state machine and done flags.

Test Plan:
- Reset release with defaults → every channel pulses on clk 2, 4, 6…; 24 pulses in 48 clk.
- Write ch1 num=1 den=12 → cfg_busy high until ch1's next pulse; afterwards exactly 1 pulse per 12 clk, with no period shorter than the old one.
- Write num=3 den=2 → cfg_err pulse one cycle later; cfg_busy=0; ch rate unchanged. A second cfg_we during busy → ignored.
- ch0 at 1/3: pause=1 for 20 clk mid-period → cen all 0 and paused=1. After release, the next pulse arrives at the remaining phase offset (acc preserved).
- Paused; channels 1/2, 1/4, num=0; step pulse → ch0 one pulse, ch1 one pulse, ch2 none; return to PAUSED within 4 clk.
- rst asserted during STEP with a pending write → all outputs at reset values next cycle; the pending write is lost and defaults resume.
